// File: rtl/spi_flash_responder.sv
// SPI flash-side responder for the read command: oversamples SCK/SS/MOSI on the
// system clock, decodes opcode and 24-bit address, streams 32-bit memory words on MISO.
module spi_flash_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  READ_CMD    = 8'h03
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        spi_sck,
    input  logic        spi_ss,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        mem_req,
    output logic [23:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err_late,
    output logic        err_cmd
);
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

    state_t              state;
    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ADDR_W-2:0]   shift_in;
    logic [ADDR_W-1:0]   next_addr;
    logic [WORD_W-1:0]   word_buf;
    logic [WORD_W-1:0]   shift_out;
    logic                word_valid;
    logic                want_fetch;
    logic                stale;

    logic sck_rise, sck_fall, ss_high, mosi_bit;

    assign sck_rise = sck_sync[SYNC_STAGES-2] & ~sck_sync[SYNC_STAGES-1];
    assign sck_fall = ~sck_sync[SYNC_STAGES-2] & sck_sync[SYNC_STAGES-1];
    assign ss_high  = ss_sync[SYNC_STAGES-1];
    assign mosi_bit = mosi_sync[SYNC_STAGES-1];

    // Equal-depth synchronizers for the three SPI pins
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_in   <= '0;
            next_addr  <= '0;
            word_buf   <= '0;
            shift_out  <= '1;
            word_valid <= 1'b0;
            want_fetch <= 1'b0;
            stale      <= 1'b0;
            spi_miso   <= 1'b1;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            err_late   <= 1'b0;
            err_cmd    <= 1'b0;
        end else begin
            busy <= (state != IDLE) || mem_req;

            // Fetch port: one outstanding request, a full buffer blocks the next issue
            if (mem_req && mem_ack) begin
                mem_req <= 1'b0;
                stale   <= 1'b0;
                if (!stale && state == DATA && !ss_high) begin
                    word_buf   <= mem_rdata;
                    word_valid <= 1'b1;
                end
            end else if (!mem_req && want_fetch && !word_valid && !ss_high) begin
                mem_req    <= 1'b1;
                mem_addr   <= next_addr;
                want_fetch <= 1'b0;
            end

            if (ss_high) begin
                state      <= IDLE;
                bit_cnt    <= '0;
                spi_miso   <= 1'b1;
                word_valid <= 1'b0;
                want_fetch <= 1'b0;
                // A fetch still in flight belongs to a dead transaction
                if (mem_req && !mem_ack) begin
                    stale <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        state   <= CMD;
                        bit_cnt <= '0;
                    end
                    CMD: begin
                        if (sck_rise) begin
                            shift_in <= {shift_in[ADDR_W-3:0], mosi_bit};
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(7)) begin
                                bit_cnt <= '0;
                                if ({shift_in[6:0], mosi_bit} == READ_CMD) begin
                                    state <= ADDR;
                                end else begin
                                    state   <= IGNORE;
                                    err_cmd <= 1'b1;
                                end
                            end
                        end
                    end
                    ADDR: begin
                        if (sck_rise) begin
                            shift_in <= {shift_in[ADDR_W-3:0], mosi_bit};
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
                                bit_cnt    <= '0;
                                next_addr  <= {shift_in[ADDR_W-2:1], 2'b00};
                                want_fetch <= 1'b1;
                                state      <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        // bit_cnt counts rises within the current word; zero marks a word start
                        if (sck_fall) begin
                            if (bit_cnt == '0) begin
                                if (word_valid) begin
                                    spi_miso   <= word_buf[WORD_W-1];
                                    shift_out  <= {word_buf[WORD_W-2:0], 1'b1};
                                    word_valid <= 1'b0;
                                end else begin
                                    spi_miso  <= 1'b1;
                                    shift_out <= '1;
                                    err_late  <= 1'b1;
                                end
                            end else begin
                                spi_miso  <= shift_out[WORD_W-1];
                                shift_out <= {shift_out[WORD_W-2:0], 1'b1};
                            end
                        end
                        if (sck_rise) begin
                            if (bit_cnt == CNT_W'(WORD_W - 1)) begin
                                bit_cnt    <= '0;
                                next_addr  <= next_addr + ADDR_W'(4);
                                want_fetch <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    IGNORE: begin
                        spi_miso <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: an SPI master task, a latency-programmable memory
// responder and a word-stream reference model built from address arithmetic.
module tb_spi_flash_responder;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_sck = 1'b0;
    logic        spi_ss = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;
    logic        err_late;
    logic        err_cmd;

    int n_checks = 0;
    int n_pass = 0;

    spi_flash_responder #(.SYNC_STAGES(2), .READ_CMD(8'h03)) dut (
        .clock(clock), .reset_n(reset_n),
        .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .err_late(err_late), .err_cmd(err_cmd)
    );

    always #5 clock = ~clock;

    // Memory contents: explicit overrides, otherwise a salted hash of the address
    logic [31:0] mem_over [int];
    logic [31:0] mem_salt;
    function automatic logic [31:0] mem_word(input logic [23:0] a);
        if (mem_over.exists(int'(a))) return mem_over[int'(a)];
        return ({8'h00, a} * 32'h9E3779B1) ^ mem_salt;
    endfunction

    // Memory responder: latency captured when a request starts
    int          lat = 2;
    int          cur_lat = 2;
    int          req_cnt = 0;
    int          addr_glitch = 0;
    logic [23:0] held_addr = '0;
    logic [23:0] fetch_q[$];
    always @(negedge clock) begin
        if (!reset_n || !mem_req) begin
            req_cnt = 0;
            mem_ack = 1'b0;
        end else begin
            if (req_cnt == 0) begin
                fetch_q.push_back(mem_addr);
                held_addr = mem_addr;
                cur_lat = lat;
            end else if (mem_addr !== held_addr) begin
                addr_glitch++;
            end
            req_cnt++;
            mem_ack = (req_cnt == cur_lat);
            mem_rdata = mem_ack ? mem_word(held_addr) : $urandom;
        end
    end

    // SPI master, mode 0, half period in system clocks
    int   half = 8;
    logic rx_bits[$];

    task automatic spi_begin();
        @(negedge clock);
        rx_bits.delete();
        spi_ss = 1'b0;
    endtask

    task automatic spi_bit(input logic b);
        spi_mosi = b;
        repeat (half) @(negedge clock);
        rx_bits.push_back(spi_miso);
        spi_sck = 1'b1;
        repeat (half) @(negedge clock);
        spi_sck = 1'b0;
    endtask

    task automatic spi_send(input logic [31:0] v, input int nbits);
        for (int i = 0; i < nbits; i++) spi_bit(v[31-i]);
    endtask

    task automatic spi_end();
        repeat (half) @(negedge clock);
        spi_ss = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 60) begin
            @(negedge clock);
            k++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s idle timeout: busy=%b want 0", name, busy);
        else n_pass++;
        repeat (4) @(negedge clock);
    endtask

    task automatic run_read(input logic [7:0] cmd, input logic [23:0] addr, input int nwords);
        spi_begin();
        spi_send({cmd, addr}, 32);
        for (int w = 0; w < nwords; w++) spi_send(32'h0, 32);
        spi_end();
    endtask

    function automatic logic [31:0] rx_word(input int k);
        logic [31:0] w;
        for (int j = 0; j < 32; j++) w[31-j] = rx_bits[32 + 32*k + j];
        return w;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if (spi_miso !== 1'b1) $display("FAIL reset_miso: got %b want 1", spi_miso); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (mem_addr !== 24'h0) $display("FAIL reset_addr: got %h want 0", mem_addr); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (err_late !== 1'b0) $display("FAIL reset_err_late: got %b want 0", err_late); else n_pass++;
        n_checks++; if (err_cmd !== 1'b0) $display("FAIL reset_err_cmd: got %b want 0", err_cmd); else n_pass++;
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_single_read();
        int qb;
        half = 12; lat = 2;
        mem_over[32'h10] = 32'h12345678;
        qb = fetch_q.size();
        spi_begin();
        spi_send({8'h03, 24'h000010}, 32);
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
        spi_send(32'h0, 32);
        spi_end();
        wait_idle("single");
        n_checks++; if (rx_word(0) !== 32'h12345678) $display("FAIL single_data: got %h want 12345678", rx_word(0)); else n_pass++;
        n_checks++; if (fetch_q.size() <= qb || fetch_q[qb] !== 24'h000010) $display("FAIL single_addr: got %h want 000010", (fetch_q.size() > qb) ? fetch_q[qb] : 24'hxxxxxx); else n_pass++;
    endtask

    task automatic test_unaligned();
        int qb;
        half = 8; lat = 2;
        qb = fetch_q.size();
        run_read(8'h03, 24'h000013, 1);
        wait_idle("unaligned");
        n_checks++; if (rx_word(0) !== 32'h12345678) $display("FAIL unaligned_data: got %h want 12345678", rx_word(0)); else n_pass++;
        n_checks++; if (fetch_q.size() <= qb || fetch_q[qb] !== 24'h000010) $display("FAIL unaligned_addr: got %h want 000010", (fetch_q.size() > qb) ? fetch_q[qb] : 24'hxxxxxx); else n_pass++;
    endtask

    task automatic test_burst_wrap();
        int qb;
        half = 8; lat = 2;
        qb = fetch_q.size();
        run_read(8'h03, 24'hFFFFFC, 2);
        wait_idle("wrap");
        n_checks++; if (fetch_q.size() < qb + 2 || fetch_q[qb] !== 24'hFFFFFC) $display("FAIL wrap_addr0: got size %0d want fetch FFFFFC", fetch_q.size() - qb); else n_pass++;
        n_checks++; if (fetch_q.size() < qb + 2 || fetch_q[qb+1] !== 24'h000000) $display("FAIL wrap_addr1: got size %0d want fetch 000000", fetch_q.size() - qb); else n_pass++;
        n_checks++; if (rx_word(0) !== mem_word(24'hFFFFFC)) $display("FAIL wrap_word0: got %h want %h", rx_word(0), mem_word(24'hFFFFFC)); else n_pass++;
        n_checks++; if (rx_word(1) !== mem_word(24'h000000)) $display("FAIL wrap_word1: got %h want %h", rx_word(1), mem_word(24'h000000)); else n_pass++;
    endtask

    task automatic test_random_reads();
        for (int it = 0; it < 4; it++) begin
            logic [23:0] a;
            logic [23:0] base;
            int nw, qb;
            a = 24'($urandom);
            base = a & 24'hFFFFFC;
            nw = int'($urandom_range(3, 1));
            half = 2 * int'($urandom_range(5, 3));
            lat = int'($urandom_range(2, 1));
            qb = fetch_q.size();
            run_read(8'h03, a, nw);
            wait_idle("random");
            n_checks++; if (fetch_q.size() <= qb || fetch_q[qb] !== base) $display("FAIL random_addr it%0d: got size %0d want fetch %h", it, fetch_q.size() - qb, base); else n_pass++;
            for (int k = 0; k < nw; k++) begin
                logic [31:0] exp;
                exp = mem_word(base + 24'(4*k));
                n_checks++; if (rx_word(k) !== exp) $display("FAIL random_word it%0d w%0d: got %h want %h", it, k, rx_word(k), exp); else n_pass++;
            end
        end
        n_checks++; if (err_late !== 1'b0) $display("FAIL random_err_late: got %b want 0", err_late); else n_pass++;
        n_checks++; if (addr_glitch != 0) $display("FAIL addr_stable: got %0d changes want 0", addr_glitch); else n_pass++;
    endtask

    task automatic test_bad_opcode();
        int qb;
        half = 8; lat = 2;
        qb = fetch_q.size();
        run_read(8'h9F, 24'($urandom), 1);
        wait_idle("badop");
        n_checks++; if (rx_word(0) !== 32'hFFFFFFFF) $display("FAIL badop_miso: got %h want ffffffff", rx_word(0)); else n_pass++;
        n_checks++; if (fetch_q.size() != qb) $display("FAIL badop_nofetch: got %0d fetches want 0", fetch_q.size() - qb); else n_pass++;
        n_checks++; if (err_cmd !== 1'b1) $display("FAIL badop_err_cmd: got %b want 1", err_cmd); else n_pass++;
        run_read(8'h03, 24'h000010, 1);
        wait_idle("badop_next");
        n_checks++; if (rx_word(0) !== 32'h12345678) $display("FAIL badop_next_data: got %h want 12345678", rx_word(0)); else n_pass++;
    endtask

    task automatic test_abort_addr();
        int qb;
        half = 8; lat = 2;
        qb = fetch_q.size();
        spi_begin();
        spi_send({8'h03, 24'h123456}, 20);
        spi_end();
        wait_idle("abort_addr");
        n_checks++; if (fetch_q.size() != qb) $display("FAIL abort_addr_nofetch: got %0d fetches want 0", fetch_q.size() - qb); else n_pass++;
        n_checks++; if (err_late !== 1'b0) $display("FAIL abort_addr_err_late: got %b want 0", err_late); else n_pass++;
    endtask

    task automatic test_late_memory();
        logic [23:0] a;
        int qb;
        a = 24'($urandom) & 24'hFFFFF0;
        half = 4; lat = 40;
        qb = fetch_q.size();
        run_read(8'h03, a, 3);
        wait_idle("late");
        n_checks++; if (rx_word(0) !== 32'hFFFFFFFF) $display("FAIL late_word0: got %h want ffffffff", rx_word(0)); else n_pass++;
        n_checks++; if (rx_word(1) !== mem_word(a)) $display("FAIL late_word1: got %h want %h", rx_word(1), mem_word(a)); else n_pass++;
        n_checks++; if (rx_word(2) !== mem_word(a + 24'd4)) $display("FAIL late_word2: got %h want %h", rx_word(2), mem_word(a + 24'd4)); else n_pass++;
        n_checks++; if (err_late !== 1'b1) $display("FAIL late_err_late: got %b want 1", err_late); else n_pass++;
        n_checks++; if (fetch_q.size() < qb + 2 || fetch_q[qb+1] !== a + 24'd4) $display("FAIL late_addr1: got size %0d want fetch %h", fetch_q.size() - qb, a + 24'd4); else n_pass++;
    endtask

    task automatic test_abort_fetch();
        logic [23:0] a, b;
        int qb;
        a = 24'($urandom) & 24'hFFFF00;
        b = a ^ 24'h000140;
        half = 4; lat = 400;
        qb = fetch_q.size();
        spi_begin();
        spi_send({8'h03, a}, 32);
        spi_send(32'h0, 4);
        spi_end();
        repeat (10) @(negedge clock);
        n_checks++; if (mem_req !== 1'b1) $display("FAIL abort_req_held: got %b want 1", mem_req); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL abort_busy: got %b want 1", busy); else n_pass++;
        lat = 2;
        run_read(8'h03, b, 2);
        wait_idle("abort_fetch");
        n_checks++; if (fetch_q.size() < qb + 2 || fetch_q[qb] !== a) $display("FAIL abort_first_addr: got size %0d want fetch %h", fetch_q.size() - qb, a); else n_pass++;
        n_checks++; if (fetch_q.size() < qb + 2 || fetch_q[qb+1] !== b) $display("FAIL abort_second_addr: got size %0d want fetch %h", fetch_q.size() - qb, b); else n_pass++;
        n_checks++; if (rx_word(0) !== 32'hFFFFFFFF) $display("FAIL abort_word0: got %h want ffffffff", rx_word(0)); else n_pass++;
        n_checks++; if (rx_word(1) !== mem_word(b)) $display("FAIL abort_word1: got %h want %h", rx_word(1), mem_word(b)); else n_pass++;
    endtask

    task automatic test_reset_mid_data();
        half = 8; lat = 2;
        mem_over[32'h200] = 32'h00000000;
        spi_begin();
        spi_send({8'h03, 24'h000200}, 32);
        spi_send(32'h0, 8);
        repeat (3) @(negedge clock);
        n_checks++; if (spi_miso !== 1'b0) $display("FAIL midreset_pre_miso: got %b want 0", spi_miso); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (spi_miso !== 1'b1) $display("FAIL midreset_miso: got %b want 1", spi_miso); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL midreset_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (err_late !== 1'b0) $display("FAIL midreset_err_late: got %b want 0", err_late); else n_pass++;
        n_checks++; if (err_cmd !== 1'b0) $display("FAIL midreset_err_cmd: got %b want 0", err_cmd); else n_pass++;
        spi_ss = 1'b1;
        spi_sck = 1'b0;
        repeat (4) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        run_read(8'h03, 24'h000010, 1);
        wait_idle("post_reset");
        n_checks++; if (rx_word(0) !== 32'h12345678) $display("FAIL post_reset_data: got %h want 12345678", rx_word(0)); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        mem_salt = $urandom;
        test_reset();
        test_single_read();
        test_unaligned();
        test_burst_wrap();
        test_random_reads();
        test_bad_opcode();
        test_abort_addr();
        test_late_memory();
        test_abort_fetch();
        test_reset_mid_data();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
